jtag_tap_controller: RTL and testbench

//  IEEE 1149.1 TAP state machine and DR/IR sequencer. Advances on sampled TMS and drives the
//  tap_reset/capture/shift/update strobes consumed by jtag_instruction_register and DR chains.

---
 rtl/jtag_pkg.sv | 45 ++++
 rtl/jtag_tap_fsm.sv | 78 +++++++
 rtl/jtag_tap_controller.sv | 142 ++++++++++++++
 tb/tb_jtag_tap_controller.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtag_pkg
// Description : Shared types and constants for the JTAG TAP slice.
//               - tap_state_t : 4-bit IEEE 1149.1 TAP state encoding
//               - IR_* codes  : instruction codes decoded into DR selects
//               - dr_sel_t    : one-hot DR select vector
// Revision    : 1.0 - initial release
// ============================================================================
package jtag_pkg;

  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PAU_DR = 4'h3,
    EX2_DR = 4'h0,
    UPD_DR = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PAU_IR = 4'hB,
    EX2_IR = 4'h8,
    UPD_IR = 4'hD
  } tap_state_t;

  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_DTMCS  = 5'h10;
  localparam logic [4:0] IR_DMI    = 5'h11;
  localparam logic [4:0] IR_BYPASS = 5'h1F;

  // One-hot DR select, bit order {idcode, dtmcs, dmi, bypass}
  typedef logic [3:0] dr_sel_t;

  localparam dr_sel_t DR_SEL_IDCODE = 4'b1000;
  localparam dr_sel_t DR_SEL_DTMCS  = 4'b0100;
  localparam dr_sel_t DR_SEL_DMI    = 4'b0010;
  localparam dr_sel_t DR_SEL_BYPASS = 4'b0001;

endpackage
`default_nettype wire

// File: rtl/jtag_tap_fsm.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_fsm
// Description : TAP state register and next-state logic.
//               Optional macro JTAG_TRST_EN adds a synchronous active-low
//               trst_n input with the same priority as rst_n.
// Ports       : clk        in  TAP clock
//               rst_n      in  synchronous active-low reset
//               trst_n     in  synchronous active-low test reset (JTAG_TRST_EN)
//               tms        in  test mode select
//               state      out current TAP state
//               next_state out state to be loaded on the next posedge,
//                              including the effect of any reset
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
`ifdef JTAG_TRST_EN
  input  logic       trst_n,
`endif
  input  logic       tms,
  output tap_state_t state,
  output tap_state_t next_state
);

  tap_state_t r_state;
  tap_state_t w_next_tms;
  logic       w_rst;

`ifdef JTAG_TRST_EN
  assign w_rst = ~rst_n | ~trst_n;
`else
  assign w_rst = ~rst_n;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state <= TLR;
    end else begin
      r_state <= w_next_tms;
    end
  end

  // Next-state logic driven purely by TMS
  always_comb begin
    w_next_tms = TLR;
    case (r_state)
      TLR:     w_next_tms = tms ? TLR    : RTI;
      RTI:     w_next_tms = tms ? SEL_DR : RTI;
      SEL_DR:  w_next_tms = tms ? SEL_IR : CAP_DR;
      CAP_DR:  w_next_tms = tms ? EX1_DR : SH_DR;
      SH_DR:   w_next_tms = tms ? EX1_DR : SH_DR;
      EX1_DR:  w_next_tms = tms ? UPD_DR : PAU_DR;
      PAU_DR:  w_next_tms = tms ? EX2_DR : PAU_DR;
      EX2_DR:  w_next_tms = tms ? UPD_DR : SH_DR;
      UPD_DR:  w_next_tms = tms ? SEL_DR : RTI;
      SEL_IR:  w_next_tms = tms ? TLR    : CAP_IR;
      CAP_IR:  w_next_tms = tms ? EX1_IR : SH_IR;
      SH_IR:   w_next_tms = tms ? EX1_IR : SH_IR;
      EX1_IR:  w_next_tms = tms ? UPD_IR : PAU_IR;
      PAU_IR:  w_next_tms = tms ? EX2_IR : PAU_IR;
      EX2_IR:  w_next_tms = tms ? UPD_IR : SH_IR;
      UPD_IR:  w_next_tms = tms ? SEL_DR : RTI;
      default: w_next_tms = TLR;
    endcase
  end

  assign state      = r_state;
  // Exposing the reset-qualified next state lets the dwell counter clear on
  // reset without duplicating the reset sources.
  assign next_state = w_rst ? TLR : w_next_tms;

endmodule
`default_nettype wire

// File: rtl/jtag_tap_controller.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_controller
// Description : IEEE 1149.1 TAP controller and DR/IR sequencer. Decodes the
//               TAP state into Moore strobes, decodes the latched instruction
//               into one-hot DR selects, muxes TDO and counts RTI dwell.
//               Optional macro JTAG_TRST_EN adds the trst_n input.
// Ports       : clk, rst_n, [trst_n], tms        control inputs
//               ir_value                         latched instruction
//               ir_tdo/idcode_tdo/dtmcs_tdo/dmi_tdo/bypass_tdo  serial ins
//               tap_state                        current TAP state
//               tap_reset, capture/shift/update _ir/_dr         strobes
//               sel_idcode/sel_dtmcs/sel_dmi/sel_bypass         DR select
//               rti_cycles                       saturating RTI dwell count
//               tdo, tdo_oe                      serial out and enable
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_controller
  import jtag_pkg::*;
#(
  parameter int IR_W      = 5,
  parameter int RTI_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef JTAG_TRST_EN
  input  logic                 trst_n,
`endif
  input  logic                 tms,
  input  logic [IR_W-1:0]      ir_value,
  input  logic                 ir_tdo,
  input  logic                 idcode_tdo,
  input  logic                 dtmcs_tdo,
  input  logic                 dmi_tdo,
  input  logic                 bypass_tdo,
  output tap_state_t           tap_state,
  output logic                 tap_reset,
  output logic                 capture_ir,
  output logic                 shift_ir,
  output logic                 update_ir,
  output logic                 capture_dr,
  output logic                 shift_dr,
  output logic                 update_dr,
  output logic                 sel_idcode,
  output logic                 sel_dtmcs,
  output logic                 sel_dmi,
  output logic                 sel_bypass,
  output logic [RTI_CNT_W-1:0] rti_cycles,
  output logic                 tdo,
  output logic                 tdo_oe
);

  localparam logic [RTI_CNT_W-1:0] c_rti_max = '1;

  tap_state_t             w_state;
  tap_state_t             w_next_state;
  dr_sel_t                w_dr_sel;
  logic                   w_dr_tdo;
  logic [RTI_CNT_W-1:0]   r_rti_cycles;

  jtag_tap_fsm u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef JTAG_TRST_EN
    .trst_n     (trst_n),
`endif
    .tms        (tms),
    .state      (w_state),
    .next_state (w_next_state)
  );

  assign tap_state = w_state;

  // Moore strobe decode: each strobe is a function of the state only
  always_comb begin
    tap_reset  = (w_state == TLR);
    capture_ir = (w_state == CAP_IR);
    shift_ir   = (w_state == SH_IR);
    update_ir  = (w_state == UPD_IR);
    capture_dr = (w_state == CAP_DR);
    shift_dr   = (w_state == SH_DR);
    update_dr  = (w_state == UPD_DR);
  end

  // Instruction decode; unknown codes fall back to BYPASS so exactly one
  // select is always active.
  always_comb begin
    w_dr_sel = DR_SEL_BYPASS;
    if (ir_value == IR_W'(IR_IDCODE)) begin
      w_dr_sel = DR_SEL_IDCODE;
    end else if (ir_value == IR_W'(IR_DTMCS)) begin
      w_dr_sel = DR_SEL_DTMCS;
    end else if (ir_value == IR_W'(IR_DMI)) begin
      w_dr_sel = DR_SEL_DMI;
    end
  end

  assign sel_idcode = w_dr_sel[3];
  assign sel_dtmcs  = w_dr_sel[2];
  assign sel_dmi    = w_dr_sel[1];
  assign sel_bypass = w_dr_sel[0];

  // TDO mux
  always_comb begin
    w_dr_tdo = bypass_tdo;
    case (w_dr_sel)
      DR_SEL_IDCODE: w_dr_tdo = idcode_tdo;
      DR_SEL_DTMCS:  w_dr_tdo = dtmcs_tdo;
      DR_SEL_DMI:    w_dr_tdo = dmi_tdo;
      default:       w_dr_tdo = bypass_tdo;
    endcase
  end

  always_comb begin
    tdo = 1'b0;
    if (shift_ir) begin
      tdo = ir_tdo;
    end else if (shift_dr) begin
      tdo = w_dr_tdo;
    end
  end

  assign tdo_oe = shift_ir | shift_dr;

  // RTI dwell counter. next_state already folds in every reset source, so
  // any reset clears the count through the "leaving RTI" branch as well.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rti_cycles <= '0;
    end else if ((w_state == RTI) && (w_next_state == RTI)) begin
      if (r_rti_cycles != c_rti_max) begin
        r_rti_cycles <= r_rti_cycles + RTI_CNT_W'(1);
      end
    end else begin
      r_rti_cycles <= '0;
    end
  end

  assign rti_cycles = r_rti_cycles;

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_tap_controller
// Description : Directed self-checking bench for jtag_tap_controller.
//               The bench stands in for the instruction register by driving
//               ir_value itself. Honours JTAG_TRST_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_tap_controller;

  logic       clk = 1'b0;
  logic       rst_n;
`ifdef JTAG_TRST_EN
  logic       trst_n;
`endif
  logic       tms;
  logic [4:0] ir_value;
  logic       ir_tdo, idcode_tdo, dtmcs_tdo, dmi_tdo, bypass_tdo;
  logic [3:0] tap_state;
  logic       tap_reset, capture_ir, shift_ir, update_ir;
  logic       capture_dr, shift_dr, update_dr;
  logic       sel_idcode, sel_dtmcs, sel_dmi, sel_bypass;
  logic [7:0] rti_cycles;
  logic       tdo, tdo_oe;

  int pass_cnt  = 0;
  int check_cnt = 0;

  // Paths from TLR to every state, tms bits LSB first
  logic [7:0] seq_bits [16];
  int         seq_len  [16];
  logic [3:0] seq_exp  [16];

  always #5 clk = ~clk;

  jtag_tap_controller #(.IR_W(5), .RTI_CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef JTAG_TRST_EN
    .trst_n     (trst_n),
`endif
    .tms        (tms),
    .ir_value   (ir_value),
    .ir_tdo     (ir_tdo),
    .idcode_tdo (idcode_tdo),
    .dtmcs_tdo  (dtmcs_tdo),
    .dmi_tdo    (dmi_tdo),
    .bypass_tdo (bypass_tdo),
    .tap_state  (tap_state),
    .tap_reset  (tap_reset),
    .capture_ir (capture_ir),
    .shift_ir   (shift_ir),
    .update_ir  (update_ir),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .sel_idcode (sel_idcode),
    .sel_dtmcs  (sel_dtmcs),
    .sel_dmi    (sel_dmi),
    .sel_bypass (sel_bypass),
    .rti_cycles (rti_cycles),
    .tdo        (tdo),
    .tdo_oe     (tdo_oe)
  );

  // Expected strobe vector {tap_reset,cap_ir,sh_ir,upd_ir,cap_dr,sh_dr,upd_dr}
  function automatic logic [6:0] exp_strobes(input logic [3:0] st);
    case (st)
      4'hF:    return 7'b1000000;
      4'hE:    return 7'b0100000;
      4'hA:    return 7'b0010000;
      4'hD:    return 7'b0001000;
      4'h6:    return 7'b0000100;
      4'h2:    return 7'b0000010;
      4'h5:    return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] strobes();
    return {tap_reset, capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr};
  endfunction

  task automatic step(input logic t);
    tms = t;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    ir_value = 5'h01;
    step(1'b1);
    rst_n    = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    ir_value = 5'h01;
    step(1'b0);
    step(1'b0);
    check_cnt++;
    if (tap_state !== 4'hF) $display("FAIL reset_state got=%h exp=%h", tap_state, 4'hF);
    else pass_cnt++;
    check_cnt++;
    if (strobes() !== 7'b1000000) $display("FAIL reset_strobes got=%b exp=%b", strobes(), 7'b1000000);
    else pass_cnt++;
    check_cnt++;
    if ({sel_idcode, sel_dtmcs, sel_dmi, sel_bypass} !== 4'b1000)
      $display("FAIL reset_sel got=%b exp=%b", {sel_idcode, sel_dtmcs, sel_dmi, sel_bypass}, 4'b1000);
    else pass_cnt++;
    check_cnt++;
    if ({tdo_oe, tdo, rti_cycles} !== 10'd0)
      $display("FAIL reset_tdo_rti got=%b/%b/%0d exp=0/0/0", tdo_oe, tdo, rti_cycles);
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_rti_count();
    do_reset();
    step(1'b0);
    check_cnt++;
    if ({tap_state, tap_reset, rti_cycles} !== {4'hC, 1'b0, 8'd0})
      $display("FAIL rti_entry got=%h/%b/%0d exp=c/0/0", tap_state, tap_reset, rti_cycles);
    else pass_cnt++;
    for (int k = 1; k <= 3; k++) begin
      step(1'b0);
      check_cnt++;
      if (rti_cycles !== 8'(k)) $display("FAIL rti_count got=%0d exp=%0d", rti_cycles, k);
      else pass_cnt++;
    end
    repeat (300) step(1'b0);
    check_cnt++;
    if (rti_cycles !== 8'd255) $display("FAIL rti_saturate got=%0d exp=255", rti_cycles);
    else pass_cnt++;
    step(1'b1);
    check_cnt++;
    if ({tap_state, rti_cycles} !== {4'h7, 8'd0})
      $display("FAIL rti_leave got=%h/%0d exp=7/0", tap_state, rti_cycles);
    else pass_cnt++;
  endtask

  task automatic test_all_states_to_tlr();
    seq_bits = '{8'h00, 8'h00, 8'h02, 8'h02, 8'h02, 8'h0A, 8'h0A, 8'h2A,
                 8'h1A, 8'h06, 8'h06, 8'h06, 8'h16, 8'h16, 8'h56, 8'h36};
    seq_len  = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};
    seq_exp  = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0,
                 4'h5, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};
    for (int i = 0; i < 16; i++) begin
      do_reset();
      for (int b = 0; b < seq_len[i]; b++) step(seq_bits[i][b]);
      check_cnt++;
      if ({tap_state, strobes()} !== {seq_exp[i], exp_strobes(seq_exp[i])})
        $display("FAIL path_state[%0d] got=%h/%b exp=%h/%b", i, tap_state, strobes(),
                 seq_exp[i], exp_strobes(seq_exp[i]));
      else pass_cnt++;
      repeat (5) step(1'b1);
      check_cnt++;
      if ({tap_state, tap_reset} !== {4'hF, 1'b1})
        $display("FAIL tms5_to_tlr[%0d] got=%h/%b exp=f/1", i, tap_state, tap_reset);
      else pass_cnt++;
    end
  endtask

  task automatic test_ir_load();
    logic [4:0] ir_bits;
    ir_bits = 5'h11;
    do_reset();
    step(1'b0);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    check_cnt++;
    if ({tap_state, capture_ir, shift_ir} !== {4'hE, 1'b1, 1'b0})
      $display("FAIL ir_capture got=%h/%b/%b exp=e/1/0", tap_state, capture_ir, shift_ir);
    else pass_cnt++;
    step(1'b0);
    {ir_tdo, idcode_tdo, dtmcs_tdo, dmi_tdo, bypass_tdo} = 5'b10000;
    #1;
    check_cnt++;
    if ({tap_state, capture_ir, shift_ir, tdo_oe, tdo} !== {4'hA, 4'b0111})
      $display("FAIL ir_shift got=%h/%b%b%b%b exp=a/0111", tap_state, capture_ir, shift_ir, tdo_oe, tdo);
    else pass_cnt++;
    for (int b = 0; b < 5; b++) begin
      ir_tdo = ir_bits[b];
      step(b == 4);
    end
    check_cnt++;
    if (tap_state !== 4'h9) $display("FAIL ir_exit1 got=%h exp=9", tap_state);
    else pass_cnt++;
    step(1'b1);
    check_cnt++;
    if ({tap_state, update_ir} !== {4'hD, 1'b1})
      $display("FAIL ir_update got=%h/%b exp=d/1", tap_state, update_ir);
    else pass_cnt++;
    ir_value = 5'h11;
    step(1'b0);
    check_cnt++;
    if ({sel_idcode, sel_dtmcs, sel_dmi, sel_bypass} !== 4'b0010)
      $display("FAIL sel_dmi got=%b exp=0010", {sel_idcode, sel_dtmcs, sel_dmi, sel_bypass});
    else pass_cnt++;
    step(1'b1);
    step(1'b0);
    step(1'b0);
    {ir_tdo, idcode_tdo, dtmcs_tdo, dmi_tdo, bypass_tdo} = 5'b00010;
    #1;
    check_cnt++;
    if ({tap_state, shift_dr, tdo_oe, tdo} !== {4'h2, 3'b111})
      $display("FAIL dr_shift_dmi1 got=%h/%b%b%b exp=2/111", tap_state, shift_dr, tdo_oe, tdo);
    else pass_cnt++;
    {ir_tdo, idcode_tdo, dtmcs_tdo, dmi_tdo, bypass_tdo} = 5'b11101;
    #1;
    check_cnt++;
    if ({tdo_oe, tdo} !== 2'b10) $display("FAIL dr_shift_dmi0 got=%b%b exp=10", tdo_oe, tdo);
    else pass_cnt++;
  endtask

  task automatic test_decode();
    do_reset();
    step(1'b0);
    {ir_tdo, idcode_tdo, dtmcs_tdo, dmi_tdo, bypass_tdo} = 5'b11111;
    ir_value = 5'h05;
    #1;
    check_cnt++;
    if ({sel_idcode, sel_dtmcs, sel_dmi, sel_bypass, tdo_oe, tdo} !== 6'b000100)
      $display("FAIL dec_05 got=%b exp=000100", {sel_idcode, sel_dtmcs, sel_dmi, sel_bypass, tdo_oe, tdo});
    else pass_cnt++;
    ir_value = 5'h10;
    #1;
    check_cnt++;
    if ({sel_idcode, sel_dtmcs, sel_dmi, sel_bypass, tdo_oe, tdo} !== 6'b010000)
      $display("FAIL dec_10 got=%b exp=010000", {sel_idcode, sel_dtmcs, sel_dmi, sel_bypass, tdo_oe, tdo});
    else pass_cnt++;
    ir_value = 5'h1F;
    #1;
    check_cnt++;
    if ({sel_idcode, sel_dtmcs, sel_dmi, sel_bypass} !== 4'b0001)
      $display("FAIL dec_1f got=%b exp=0001", {sel_idcode, sel_dtmcs, sel_dmi, sel_bypass});
    else pass_cnt++;
    // Walk to SH_DR with DTMCS selected; only dtmcs_tdo may reach tdo
    ir_value = 5'h10;
    step(1'b1);
    step(1'b0);
    step(1'b0);
    {ir_tdo, idcode_tdo, dtmcs_tdo, dmi_tdo, bypass_tdo} = 5'b11011;
    #1;
    check_cnt++;
    if ({tdo_oe, tdo} !== 2'b10) $display("FAIL dtmcs_tdo0 got=%b%b exp=10", tdo_oe, tdo);
    else pass_cnt++;
    {ir_tdo, idcode_tdo, dtmcs_tdo, dmi_tdo, bypass_tdo} = 5'b00100;
    #1;
    check_cnt++;
    if ({tdo_oe, tdo} !== 2'b11) $display("FAIL dtmcs_tdo1 got=%b%b exp=11", tdo_oe, tdo);
    else pass_cnt++;
    ir_value = 5'h1F;
    {ir_tdo, idcode_tdo, dtmcs_tdo, dmi_tdo, bypass_tdo} = 5'b00001;
    #1;
    check_cnt++;
    if ({tdo_oe, tdo} !== 2'b11) $display("FAIL bypass_tdo got=%b%b exp=11", tdo_oe, tdo);
    else pass_cnt++;
  endtask

  task automatic test_pause_path();
    logic [4:0] pat;
    logic [3:0] exp_st [5];
    int         upd_seen;
    pat      = 5'b01001;
    exp_st   = '{4'h1, 4'h3, 4'h3, 4'h0, 4'h2};
    upd_seen = 0;
    do_reset();
    step(1'b0);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    for (int k = 0; k < 5; k++) begin
      step(pat[k]);
      if (update_dr) upd_seen++;
      check_cnt++;
      if ({tap_state, strobes()} !== {exp_st[k], exp_strobes(exp_st[k])})
        $display("FAIL pause_path[%0d] got=%h/%b exp=%h/%b", k, tap_state, strobes(),
                 exp_st[k], exp_strobes(exp_st[k]));
      else pass_cnt++;
    end
    check_cnt++;
    if (upd_seen !== 0) $display("FAIL pause_no_update got=%0d exp=0", upd_seen);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_shift();
    do_reset();
    step(1'b0);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    check_cnt++;
    if (tap_state !== 4'hA) $display("FAIL mid_ir_setup got=%h exp=a", tap_state);
    else pass_cnt++;
    rst_n = 1'b0;
    step(1'b0);
    check_cnt++;
    if ({tap_state, strobes(), tdo_oe} !== {4'hF, 7'b1000000, 1'b0})
      $display("FAIL rst_mid_shift got=%h/%b/%b exp=f/1000000/0", tap_state, strobes(), tdo_oe);
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

`ifdef JTAG_TRST_EN
  task automatic test_trst();
    do_reset();
    step(1'b0);
    step(1'b0);
    step(1'b0);
    check_cnt++;
    if (rti_cycles !== 8'd2) $display("FAIL trst_rti_pre got=%0d exp=2", rti_cycles);
    else pass_cnt++;
    step(1'b1);
    step(1'b0);
    step(1'b0);
    check_cnt++;
    if (tap_state !== 4'h2) $display("FAIL trst_sh_dr got=%h exp=2", tap_state);
    else pass_cnt++;
    trst_n = 1'b0;
    step(1'b0);
    trst_n = 1'b1;
    check_cnt++;
    if ({tap_state, tap_reset, rti_cycles} !== {4'hF, 1'b1, 8'd0})
      $display("FAIL trst_to_tlr got=%h/%b/%0d exp=f/1/0", tap_state, tap_reset, rti_cycles);
    else pass_cnt++;
    step(1'b0);
    step(1'b0);
    check_cnt++;
    if ({tap_state, rti_cycles} !== {4'hC, 8'd1})
      $display("FAIL trst_high_normal got=%h/%0d exp=c/1", tap_state, rti_cycles);
    else pass_cnt++;
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    tms        = 1'b1;
    ir_value   = 5'h01;
    ir_tdo     = 1'b0;
    idcode_tdo = 1'b0;
    dtmcs_tdo  = 1'b0;
    dmi_tdo    = 1'b0;
    bypass_tdo = 1'b0;
`ifdef JTAG_TRST_EN
    trst_n     = 1'b1;
`endif
    #2;
    test_reset();
    test_rti_count();
    test_all_states_to_tlr();
    test_ir_load();
    test_decode();
    test_pause_path();
    test_reset_mid_shift();
`ifdef JTAG_TRST_EN
    test_trst();
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
`default_nettype wire
